instr_fetch_64: RTL and testbench

Instruction fetch stage for the 64-bit multicycle core, sitting directly upstream of the instruction register. It owns the program counter, issues word reads to instruction memory over a request/valid handshake, and captures the returned 32-bit word. It then presents the word on `instruction` with a one-cycle `load_ir` strobe, which the instruction register consumes. It holds that instruction until the control unit signals `advance`, then updates the PC sequentially or to a branch target.

---
 rtl/instr_fetch_64_if.sv | 22 ++
 rtl/instr_fetch_64.sv | 121 ++++++++++++
 tb/tb_instr_fetch_64.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_64_if.sv
// Instruction-memory read port of the fetch stage: a one-cycle request with an
// address, answered later by a valid strobe carrying the 32-bit word.
interface instr_fetch_64_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_64.sv
// Instruction fetch stage: owns the PC, reads one word per fetch from
// instruction memory and hands it to the instruction register with load_ir.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no fetch in progress, waiting for fetch_en
//   REQ   | imem_req pulse (or misaligned-PC detection)
//   WAIT  | waiting for imem_valid, counting towards the timeout
//   LOAD  | load_ir strobe, instruction captured
//   HOLD  | instruction held until the control unit advances
//   FAULT | sticky timeout/misaligned fault, left only by reset
module instr_fetch_64 #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    instr_fetch_64_if.master        imem,
    output logic                    load_ir,
    output logic [31:0]             instruction,
    output logic [63:0]             pc,
    input  logic                    advance,
    input  logic                    pc_write,
    input  logic [63:0]             pc_next,
    output logic                    busy,
    output logic                    fault,
    output logic                    misaligned
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, HOLD, FAULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        req_q;
    logic [63:0] pc_adv;

    assign pc_adv         = pc_write ? pc_next : pc + 64'd4;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req_q;

    // The request strobe is decided on the edge entering REQ so it is high
    // exactly during the REQ cycle; a misaligned PC never raises it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            wait_cnt    <= '0;
            req_q       <= 1'b0;
            load_ir     <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            req_q   <= 1'b0;
            load_ir <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state <= REQ;
                        busy  <= 1'b1;
                        req_q <= (pc[1:0] == 2'b00);
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    if (pc[1:0] != 2'b00) begin
                        state      <= FAULT;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        misaligned <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_valid) begin
                        instruction <= imem.imem_rdata;
                        load_ir     <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // this is the MAX_WAIT-th empty WAIT cycle
                        if (wait_cnt == WAIT_LAST) begin
                            state      <= FAULT;
                            busy       <= 1'b0;
                            fault      <= 1'b1;
                            misaligned <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    state <= HOLD;
                    busy  <= 1'b0;
                end
                HOLD: begin
                    if (advance) begin
                        pc <= pc_adv;
                        if (fetch_en) begin
                            state <= REQ;
                            busy  <= 1'b1;
                            req_q <= (pc_adv[1:0] == 2'b00);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_64.sv
// Self-checking bench for instr_fetch_64: a latency-programmable memory model
// answers requests, and expected addresses/words go through scoreboard queues.
module tb_instr_fetch_64;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        fetch_en2;
    logic        advance;
    logic        pc_write;
    logic [63:0] pc_next;

    logic        load_ir, busy, fault, misaligned;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        load_ir2, busy2, fault2, misaligned2;
    logic [31:0] instruction2;
    logic [63:0] pc2;

    instr_fetch_64_if bus ();
    instr_fetch_64_if bus2 ();

    instr_fetch_64 #(.RESET_PC(64'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem(bus),
        .load_ir(load_ir), .instruction(instruction), .pc(pc),
        .advance(advance), .pc_write(pc_write), .pc_next(pc_next),
        .busy(busy), .fault(fault), .misaligned(misaligned)
    );

    instr_fetch_64 #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .MAX_WAIT(15)) dut2 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en2), .imem(bus2),
        .load_ir(load_ir2), .instruction(instruction2), .pc(pc2),
        .advance(advance), .pc_write(pc_write), .pc_next(pc_next),
        .busy(busy2), .fault(fault2), .misaligned(misaligned2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 1;               // 0 = memory never answers
    int resp_lat;
    logic [63:0] resp_addr;
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address A is A[31:0] + 0x1A4.
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && mem_lat > 0) begin
                resp_lat  = mem_lat;
                resp_addr = bus.imem_addr;
                repeat (resp_lat) @(negedge clk);
                bus.imem_valid = 1'b1;
                bus.imem_rdata = resp_addr[31:0] + 32'h1A4;
                @(negedge clk);
                bus.imem_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic observe(input int max_cyc, output int req_at, output int load_at,
                           output int nreq, output int nload,
                           output logic [63:0] req_addr, output logic [31:0] instr);
        req_at = -1; load_at = -1; nreq = 0; nload = 0; req_addr = '0; instr = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                nreq++;
                if (req_at < 0) begin req_at = i; req_addr = bus.imem_addr; end
            end
            if (load_ir === 1'b1) begin
                nload++;
                if (load_at < 0) begin load_at = i; instr = instruction; end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h0); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        n_cmp++; if ({load_ir, busy, fault, misaligned, bus.imem_req} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {load_ir, busy, fault, misaligned, bus.imem_req});
        end
        n_cmp++; if (pc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL reset_pc2: got %h expected fffffffffffffffc", pc2); end
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch();
        int req_at, load_at, nreq, nload;
        logic [63:0] ra; logic [31:0] ins;
        mem_lat = 1;
        fetch_en = 1'b1;
        exp_addr_q.push_back(64'h0);
        exp_data_q.push_back(32'h0000_01A4);
        observe(6, req_at, load_at, nreq, nload, ra, ins);
        n_cmp++; if (req_at !== 1) begin n_err++; $display("FAIL basic_req_cycle: got %0d expected 1", req_at); end
        n_cmp++; if (ra !== exp_addr_q[0]) begin n_err++; $display("FAIL basic_addr: got %h expected %h", ra, exp_addr_q[0]); end
        void'(exp_addr_q.pop_front());
        n_cmp++; if (load_at !== 3 || nload !== 1) begin n_err++; $display("FAIL basic_load: got cycle %0d count %0d expected cycle 3 count 1", load_at, nload); end
        n_cmp++; if (ins !== exp_data_q[0]) begin n_err++; $display("FAIL basic_instr: got %h expected %h", ins, exp_data_q[0]); end
        void'(exp_data_q.pop_front());
        n_cmp++; if (instruction !== 32'd420 || busy !== 1'b0 || nreq !== 1) begin
            n_err++; $display("FAIL basic_hold: got instr %0d busy %b reqs %0d expected 420 0 1", instruction, busy, nreq);
        end
    endtask

    task automatic test_sequential();
        int req_at, load_at, nreq, nload;
        logic [63:0] ra; logic [31:0] ins;
        mem_lat = 1;
        for (int k = 1; k <= 3; k++) begin
            advance = 1'b1; pc_write = 1'b0;
            exp_addr_q.push_back(64'(4 * k));
            exp_data_q.push_back(32'(4 * k) + 32'h1A4);
            @(negedge clk);
            advance = 1'b0;
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr_q[0]) begin
                n_err++; $display("FAIL seq_req%0d: got req %b addr %h expected 1 %h", k, bus.imem_req, bus.imem_addr, exp_addr_q[0]);
            end
            void'(exp_addr_q.pop_front());
            observe(5, req_at, load_at, nreq, nload, ra, ins);
            n_cmp++; if (load_at !== 2 || nload !== 1 || ins !== exp_data_q[0]) begin
                n_err++; $display("FAIL seq_load%0d: got cycle %0d count %0d instr %h expected 2 1 %h", k, load_at, nload, ins, exp_data_q[0]);
            end
            void'(exp_data_q.pop_front());
        end
        n_cmp++; if (pc !== 64'd12) begin n_err++; $display("FAIL seq_pc: got %0d expected 12", pc); end
    endtask

    task automatic test_branch();
        mem_lat = 1;
        advance = 1'b1; pc_write = 1'b1; pc_next = 64'h100;
        exp_addr_q.push_back(64'h100);
        exp_data_q.push_back(32'h100 + 32'h1A4);
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr_q[0]) begin
            n_err++; $display("FAIL branch_req: got req %b addr %h expected 1 %h", bus.imem_req, bus.imem_addr, exp_addr_q[0]);
        end
        void'(exp_addr_q.pop_front());
        // keep advance/pc_write asserted through REQ and WAIT: they must be ignored
        pc_next = 64'h200;
        @(negedge clk);
        @(negedge clk);
        advance = 1'b0; pc_write = 1'b0;
        n_cmp++; if (load_ir !== 1'b1 || instruction !== exp_data_q[0]) begin
            n_err++; $display("FAIL branch_load: got load %b instr %h expected 1 %h", load_ir, instruction, exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
        @(negedge clk);
        n_cmp++; if (pc !== 64'h100 || busy !== 1'b0) begin
            n_err++; $display("FAIL branch_ignore: got pc %h busy %b expected 100 0", pc, busy);
        end
    endtask

    task automatic test_slow_memory();
        int req_at, load_at, nreq, nload;
        logic [63:0] ra; logic [31:0] ins;
        mem_lat = 5;
        advance = 1'b1; pc_write = 1'b0;
        exp_data_q.push_back(32'h104 + 32'h1A4);
        @(negedge clk);
        advance = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h104) begin
            n_err++; $display("FAIL slow_req: got req %b addr %h expected 1 104", bus.imem_req, bus.imem_addr);
        end
        observe(10, req_at, load_at, nreq, nload, ra, ins);
        n_cmp++; if (load_at !== 6 || nload !== 1 || ins !== exp_data_q[0]) begin
            n_err++; $display("FAIL slow_load: got cycle %0d count %0d instr %h expected 6 1 %h", load_at, nload, ins, exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL slow_fault: got %b expected 0", fault); end
    endtask

    task automatic test_misaligned();
        int nreq = 0;
        advance = 1'b1; pc_write = 1'b1; pc_next = 64'h102;
        @(negedge clk);
        advance = 1'b0; pc_write = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0 || busy !== 1'b1 || bus.imem_addr !== 64'h102) begin
            n_err++; $display("FAIL mis_req: got req %b busy %b addr %h expected 0 1 102", bus.imem_req, busy, bus.imem_addr);
        end
        @(negedge clk);
        n_cmp++; if (fault !== 1'b1 || misaligned !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL mis_fault: got fault %b mis %b busy %b expected 1 1 0", fault, misaligned, busy);
        end
        for (int i = 0; i < 6; i++) begin
            advance = (i % 2 == 0); pc_write = 1'b1; pc_next = 64'h300;
            @(negedge clk);
            if (bus.imem_req === 1'b1) nreq++;
        end
        advance = 1'b0; pc_write = 1'b0;
        n_cmp++; if (fault !== 1'b1 || pc !== 64'h102 || nreq !== 0) begin
            n_err++; $display("FAIL mis_sticky: got fault %b pc %h reqs %0d expected 1 102 0", fault, pc, nreq);
        end
    endtask

    task automatic test_timeout();
        int first_fault = -1;
        int nreq = 0;
        pulse_reset();
        mem_lat = 0;
        fetch_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) nreq++;
            if (fault === 1'b1 && first_fault < 0) first_fault = i;
        end
        n_cmp++; if (first_fault !== 17 || nreq !== 1) begin
            n_err++; $display("FAIL timeout_cycle: got fault at %0d reqs %0d expected 17 1", first_fault, nreq);
        end
        n_cmp++; if (misaligned !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL timeout_cause: got mis %b busy %b expected 0 0", misaligned, busy);
        end
        advance = 1'b1;
        repeat (8) @(negedge clk);
        advance = 1'b0;
        n_cmp++; if (fault !== 1'b1 || pc !== 64'h0) begin
            n_err++; $display("FAIL timeout_sticky: got fault %b pc %h expected 1 0", fault, pc);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fetch_en = 1'b0;
        n_cmp++; if (fault !== 1'b0 || misaligned !== 1'b0) begin
            n_err++; $display("FAIL timeout_clear: got fault %b mis %b expected 0 0", fault, misaligned);
        end
    endtask

    task automatic test_reset_mid_wait();
        int req_at, load_at, nreq, nload;
        logic [63:0] ra; logic [31:0] ins;
        pulse_reset();
        mem_lat = 1;
        fetch_en = 1'b1;
        exp_data_q.push_back(32'h1A4);
        observe(5, req_at, load_at, nreq, nload, ra, ins);
        n_cmp++; if (load_at !== 3 || ins !== exp_data_q[0]) begin
            n_err++; $display("FAIL rmw_prefetch: got cycle %0d instr %h expected 3 %h", load_at, ins, exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
        // reset together with a branch in HOLD: reset wins
        reset = 1'b1; advance = 1'b1; pc_write = 1'b1; pc_next = 64'h40;
        @(negedge clk);
        reset = 1'b0; advance = 1'b0; pc_write = 1'b0;
        n_cmp++; if (pc !== 64'h0 || instruction !== 32'h0 || bus.imem_req !== 1'b0) begin
            n_err++; $display("FAIL rst_adv: got pc %h instr %h req %b expected 0 0 0", pc, instruction, bus.imem_req);
        end
        mem_lat = 4;
        @(negedge clk);
        fetch_en = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rmw_req: got %b expected 1", bus.imem_req); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        observe(6, req_at, load_at, nreq, nload, ra, ins);
        n_cmp++; if (nload !== 0 || nreq !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmw_late_valid: got loads %0d reqs %0d busy %b expected 0 0 0", nload, nreq, busy);
        end
        n_cmp++; if (pc !== 64'h0 || instruction !== 32'h0) begin
            n_err++; $display("FAIL rmw_state: got pc %h instr %h expected 0 0", pc, instruction);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        fetch_en2 = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++; $display("FAIL wrap_req: got req %b addr %h expected 1 fffffffffffffffc", bus2.imem_req, bus2.imem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (load_ir2 !== 1'b1 || instruction2 !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL wrap_load: got load %b instr %h expected 1 deadbeef", load_ir2, instruction2);
        end
        @(negedge clk);
        advance = 1'b1; pc_write = 1'b0;
        @(negedge clk);
        advance = 1'b0;
        n_cmp++; if (pc2 !== 64'h0 || bus2.imem_req !== 1'b1 || fault2 !== 1'b0 || misaligned2 !== 1'b0) begin
            n_err++; $display("FAIL wrap_pc: got pc %h req %b fault %b mis %b expected 0 1 0 0", pc2, bus2.imem_req, fault2, misaligned2);
        end
        fetch_en2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; fetch_en2 = 1'b0;
        advance = 1'b0; pc_write = 1'b0; pc_next = '0;
        bus2.imem_valid = 1'b1;
        bus2.imem_rdata = 32'hDEAD_BEEF;
        test_reset();
        test_basic_fetch();
        test_sequential();
        test_branch();
        test_slow_memory();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
